// File: rtl/fetch_stage.sv
// fetch_stage: instruction-fetch stage of a 3-stage RISC-V pipeline.
//
// Owns the fetch PC (pc_f) and the instruction-memory request/response
// handshake, and drives the IF/DE pipeline register into decode.
// At most one memory request is outstanding.
//
// Ports:
//   clk          in   1   rising-edge clock
//   rst_n        in   1   asynchronous active-low reset
//   stall_d      in   1   decode cannot accept; hold IF/DE
//   redirect     in   1   execute resolved a taken branch / jump
//   redirect_pc  in  32   redirect target (bits [1:0] ignored)
//   imem_req     out  1   fetch request valid
//   imem_addr    out 32   fetch address (pc_f)
//   imem_gnt     in   1   memory accepted the request
//   imem_rvalid  in   1   response valid (in order, >=1 cycle after grant)
//   imem_rdata   in  32   instruction word
//   instr_d      out 32   IF/DE instruction
//   pc_d         out 32   IF/DE PC of instr_d
//   valid_d      out  1   IF/DE holds a real instruction
module fetch_stage #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        stall_d,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_gnt,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    output logic [31:0] instr_d,
    output logic [31:0] pc_d,
    output logic        valid_d
);

    // REQ: request pending; WAIT: granted, awaiting data;
    // DROP: awaiting a response that must be discarded; HOLD: data parked for decode.
    typedef enum logic [1:0] {
        ST_REQ  = 2'd0,
        ST_WAIT = 2'd1,
        ST_DROP = 2'd2,
        ST_HOLD = 2'd3
    } state_e;

    state_e      state_q,      state_d;
    logic [31:0] pc_f_q,       pc_f_d;
    logic [31:0] hold_instr_q, hold_instr_d;
    logic [31:0] hold_pc_q,    hold_pc_d;
    logic [31:0] instr_d_q,    instr_d_d;
    logic [31:0] pc_d_q,       pc_d_d;
    logic        valid_d_q,    valid_d_d;

    logic        load_s;
    logic [31:0] load_instr_s;
    logic [31:0] load_pc_s;
    logic [31:0] pc_plus4_s;
    logic [31:0] redir_pc_s;

    assign pc_plus4_s = pc_f_q + 32'd4;           // wraps modulo 2^32
    assign redir_pc_s = {redirect_pc[31:2], 2'b00};

    // A redirect suppresses the request so the stale address is never granted.
    assign imem_req  = rst_n && (state_q == ST_REQ) && !redirect;
    assign imem_addr = pc_f_q;
    assign instr_d   = instr_d_q;
    assign pc_d      = pc_d_q;
    assign valid_d   = valid_d_q;

    // Next-state, next-PC, hold buffer and IF/DE load selection.
    always_comb begin
        state_d      = state_q;
        pc_f_d       = pc_f_q;
        hold_instr_d = hold_instr_q;
        hold_pc_d    = hold_pc_q;
        load_s       = 1'b0;
        load_instr_s = imem_rdata;
        load_pc_s    = pc_f_q;

        case (state_q)
            ST_REQ: begin
                if (redirect) begin
                    pc_f_d = redir_pc_s;
                end else if (imem_gnt) begin
                    state_d = ST_WAIT;
                end else begin
                    state_d = ST_REQ;
                end
            end
            ST_WAIT: begin
                if (imem_rvalid) begin
                    if (redirect) begin
                        pc_f_d  = redir_pc_s;
                        state_d = ST_REQ;
                    end else if (stall_d) begin
                        hold_instr_d = imem_rdata;
                        hold_pc_d    = pc_f_q;
                        pc_f_d       = pc_plus4_s;
                        state_d      = ST_HOLD;
                    end else begin
                        load_s  = 1'b1;
                        pc_f_d  = pc_plus4_s;
                        state_d = ST_REQ;
                    end
                end else if (redirect) begin
                    // Response still in flight: it must be swallowed in DROP.
                    pc_f_d  = redir_pc_s;
                    state_d = ST_DROP;
                end else begin
                    state_d = ST_WAIT;
                end
            end
            ST_DROP: begin
                if (redirect) begin
                    pc_f_d = redir_pc_s;
                end else begin
                    pc_f_d = pc_f_q;
                end
                if (imem_rvalid) begin
                    state_d = ST_REQ;
                end else begin
                    state_d = ST_DROP;
                end
            end
            ST_HOLD: begin
                if (redirect) begin
                    pc_f_d  = redir_pc_s;
                    state_d = ST_REQ;
                end else if (!stall_d) begin
                    load_s       = 1'b1;
                    load_instr_s = hold_instr_q;
                    load_pc_s    = hold_pc_q;
                    state_d      = ST_REQ;
                end else begin
                    state_d = ST_HOLD;
                end
            end
            default: begin
                state_d = ST_REQ;
            end
        endcase
    end

    // IF/DE next value: flush beats stall, stall beats load, otherwise bubble.
    always_comb begin
        instr_d_d = instr_d_q;
        pc_d_d    = pc_d_q;
        valid_d_d = valid_d_q;
        if (redirect) begin
            instr_d_d = NOP_INSTR;
            valid_d_d = 1'b0;
        end else if (stall_d) begin
            valid_d_d = valid_d_q;
        end else if (load_s) begin
            instr_d_d = load_instr_s;
            pc_d_d    = load_pc_s;
            valid_d_d = 1'b1;
        end else begin
            instr_d_d = NOP_INSTR;
            valid_d_d = 1'b0;
        end
    end

    // State, PC, hold buffer and IF/DE registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_REQ;
            pc_f_q       <= RESET_PC;
            hold_instr_q <= 32'd0;
            hold_pc_q    <= 32'd0;
            instr_d_q    <= NOP_INSTR;
            pc_d_q       <= 32'd0;
            valid_d_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            pc_f_q       <= pc_f_d;
            hold_instr_q <= hold_instr_d;
            hold_pc_q    <= hold_pc_d;
            instr_d_q    <= instr_d_d;
            pc_d_q       <= pc_d_d;
            valid_d_q    <= valid_d_d;
        end
    end

endmodule

// File: tb/tb_fetch_stage.sv
// tb_fetch_stage: directed, self-checking bench for fetch_stage.
module tb_fetch_stage;

    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        stall_d = 1'b0;
    logic        redirect = 1'b0;
    logic [31:0] redirect_pc = 32'd0;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_gnt = 1'b0;
    logic        imem_rvalid = 1'b0;
    logic [31:0] imem_rdata = 32'd0;
    logic [31:0] instr_d;
    logic [31:0] pc_d;
    logic        valid_d;

    int checks = 0;
    int errors = 0;

    fetch_stage dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .stall_d     (stall_d),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_gnt    (imem_gnt),
        .imem_rvalid (imem_rvalid),
        .imem_rdata  (imem_rdata),
        .instr_d     (instr_d),
        .pc_d        (pc_d),
        .valid_d     (valid_d)
    );

    always #5 clk = ~clk;

    // Inputs change and outputs are sampled on the falling edge.
    task automatic step();
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        stall_d = 1'b0;
        redirect = 1'b0;
        imem_gnt = 1'b0;
        imem_rvalid = 1'b0;
        step();
        rst_n = 1'b1;
    endtask

    // Grant immediately, respond one cycle later, no stall.
    task automatic fetch_one(input logic [31:0] data);
        imem_gnt = 1'b1;
        step();
        imem_gnt = 1'b0;
        imem_rvalid = 1'b1;
        imem_rdata = data;
        step();
        imem_rvalid = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        step();
        checks++; if (imem_req !== 1'b0) begin errors++; $display("FAIL reset_req got %0b exp 0", imem_req); end
        checks++; if (instr_d !== NOP) begin errors++; $display("FAIL reset_instr got %h exp %h", instr_d, NOP); end
        checks++; if (pc_d !== 32'd0) begin errors++; $display("FAIL reset_pc_d got %h exp 0", pc_d); end
        checks++; if (valid_d !== 1'b0) begin errors++; $display("FAIL reset_valid got %0b exp 0", valid_d); end
        checks++; if (imem_addr !== 32'd0) begin errors++; $display("FAIL reset_addr got %h exp 0", imem_addr); end
        rst_n = 1'b1;
        #1;
        checks++; if (imem_req !== 1'b1) begin errors++; $display("FAIL release_req got %0b exp 1", imem_req); end
    endtask

    task automatic test_first_fetch();
        do_reset();
        checks++; if (imem_addr !== 32'h0) begin errors++; $display("FAIL first_addr got %h exp 0", imem_addr); end
        fetch_one(32'h0050_0093);
        checks++; if (instr_d !== 32'h0050_0093) begin errors++; $display("FAIL first_instr got %h exp 00500093", instr_d); end
        checks++; if (pc_d !== 32'h0) begin errors++; $display("FAIL first_pc_d got %h exp 0", pc_d); end
        checks++; if (valid_d !== 1'b1) begin errors++; $display("FAIL first_valid got %0b exp 1", valid_d); end
        checks++; if (imem_addr !== 32'h4) begin errors++; $display("FAIL first_next_addr got %h exp 4", imem_addr); end
    endtask

    task automatic test_sequential();
        logic [31:0] words [4];
        words[0] = 32'h0010_0093;
        words[1] = 32'h0020_0113;
        words[2] = 32'h0030_0193;
        words[3] = 32'h0040_0213;
        do_reset();
        for (int i = 0; i < 4; i++) begin
            imem_gnt = 1'b1;
            step();
            imem_gnt = 1'b0;
            checks++; if (valid_d !== 1'b0) begin errors++; $display("FAIL seq_bubble[%0d] got %0b exp 0", i, valid_d); end
            imem_rvalid = 1'b1;
            imem_rdata = words[i];
            step();
            imem_rvalid = 1'b0;
            checks++; if (pc_d !== 32'(i * 4)) begin errors++; $display("FAIL seq_pc_d[%0d] got %h exp %h", i, pc_d, 32'(i * 4)); end
            checks++; if (instr_d !== words[i] || valid_d !== 1'b1) begin errors++; $display("FAIL seq_instr[%0d] got %h/%0b exp %h/1", i, instr_d, valid_d, words[i]); end
        end
    endtask

    task automatic test_stall_hold();
        do_reset();
        fetch_one(32'h0010_0093);
        fetch_one(32'h0020_0113);
        imem_gnt = 1'b1;
        step();
        imem_gnt = 1'b0;
        // Response for pc 0x8 arrives while decode is stalled.
        stall_d = 1'b1;
        imem_rvalid = 1'b1;
        imem_rdata = 32'h00A0_0113;
        step();
        imem_rvalid = 1'b0;
        checks++; if (instr_d !== NOP || pc_d !== 32'h4 || valid_d !== 1'b0) begin errors++; $display("FAIL stall_ifde got %h/%h/%0b exp %h/4/0", instr_d, pc_d, valid_d, NOP); end
        checks++; if (imem_req !== 1'b0) begin errors++; $display("FAIL stall_hold_req got %0b exp 0", imem_req); end
        step();
        checks++; if (instr_d !== NOP || valid_d !== 1'b0) begin errors++; $display("FAIL stall_keep got %h/%0b exp %h/0", instr_d, valid_d, NOP); end
        stall_d = 1'b0;
        step();
        checks++; if (instr_d !== 32'h00A0_0113) begin errors++; $display("FAIL unstall_instr got %h exp 00a00113", instr_d); end
        checks++; if (pc_d !== 32'h8 || valid_d !== 1'b1) begin errors++; $display("FAIL unstall_pc_d got %h/%0b exp 8/1", pc_d, valid_d); end
        checks++; if (imem_addr !== 32'hC || imem_req !== 1'b1) begin errors++; $display("FAIL unstall_addr got %h/%0b exp c/1", imem_addr, imem_req); end
    endtask

    task automatic test_redirect_drop();
        do_reset();
        fetch_one(32'h0010_0093);
        imem_gnt = 1'b1;
        step();
        imem_gnt = 1'b0;
        redirect = 1'b1;
        redirect_pc = 32'h0000_0103;
        step();
        redirect = 1'b0;
        checks++; if (imem_addr !== 32'h100) begin errors++; $display("FAIL drop_addr got %h exp 100", imem_addr); end
        checks++; if (imem_req !== 1'b0) begin errors++; $display("FAIL drop_req got %0b exp 0", imem_req); end
        checks++; if (valid_d !== 1'b0) begin errors++; $display("FAIL drop_flush got %0b exp 0", valid_d); end
        step();
        imem_rvalid = 1'b1;
        imem_rdata = 32'hDEAD_BEEF;
        step();
        imem_rvalid = 1'b0;
        checks++; if (valid_d !== 1'b0 || instr_d !== NOP) begin errors++; $display("FAIL drop_discard got %h/%0b exp %h/0", instr_d, valid_d, NOP); end
        checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h100) begin errors++; $display("FAIL drop_resume got %0b/%h exp 1/100", imem_req, imem_addr); end
        fetch_one(32'h0000_0293);
        checks++; if (pc_d !== 32'h100 || instr_d !== 32'h0000_0293 || valid_d !== 1'b1) begin errors++; $display("FAIL drop_target got %h/%h/%0b exp 100/00000293/1", pc_d, instr_d, valid_d); end
    endtask

    task automatic test_flush_beats_stall();
        do_reset();
        fetch_one(32'h0050_0093);
        redirect = 1'b1;
        stall_d = 1'b1;
        redirect_pc = 32'h0000_0200;
        #1;
        checks++; if (imem_req !== 1'b0) begin errors++; $display("FAIL redirect_req got %0b exp 0", imem_req); end
        step();
        redirect = 1'b0;
        stall_d = 1'b0;
        checks++; if (valid_d !== 1'b0 || instr_d !== NOP) begin errors++; $display("FAIL flush_stall got %h/%0b exp %h/0", instr_d, valid_d, NOP); end
        checks++; if (imem_addr !== 32'h200) begin errors++; $display("FAIL flush_addr got %h exp 200", imem_addr); end
    endtask

    task automatic test_wrap();
        redirect = 1'b1;
        redirect_pc = 32'hFFFF_FFFF;
        step();
        redirect = 1'b0;
        checks++; if (imem_addr !== 32'hFFFF_FFFC) begin errors++; $display("FAIL wrap_start got %h exp fffffffc", imem_addr); end
        fetch_one(32'h0010_0073);
        checks++; if (pc_d !== 32'hFFFF_FFFC || valid_d !== 1'b1) begin errors++; $display("FAIL wrap_pc_d got %h/%0b exp fffffffc/1", pc_d, valid_d); end
        checks++; if (imem_addr !== 32'h0) begin errors++; $display("FAIL wrap_addr got %h exp 0", imem_addr); end
    endtask

    initial begin
        test_reset();
        test_first_fetch();
        test_sequential();
        test_stall_hold();
        test_redirect_drop();
        test_flush_beats_stall();
        test_wrap();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/fetch_stage.md
Name: fetch_stage

Overview:
- Fetch stage of the 3-stage RISC-V pipeline. Owns the PC and the instruction-memory request/response handshake.
- Drives the IF/DE pipeline register. Its instruction output feeds the decode stage, including the immediate generator.
- Handles stalls from decode and redirects (taken branch, JAL, JALR) from execute.
- One outstanding memory request at most.

Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset.
- NOP_INSTR, 32'h0000_0013, instruction injected as a bubble (ADDI x0,x0,0).

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- stall_d  in  1  decode cannot accept; hold the IF/DE register.
- redirect  in  1  execute resolved a taken branch or jump.
- redirect_pc  in  32  target PC; bits [1:0] are ignored and forced to 0.
- imem_req  out  1  fetch request valid.
- imem_addr  out  32  fetch address, equal to pc_f.
- imem_gnt  in  1  memory accepted the request this cycle.
- imem_rvalid  in  1  response valid; arrives at least 1 cycle after the grant, in order.
- imem_rdata  in  32  instruction word.
- instr_d  out  32  IF/DE instruction.
- pc_d  out  32  IF/DE PC of instr_d.
- valid_d  out  1  IF/DE holds a real instruction.

Behaviour:
- Reset (async assert, sync release):
  - pc_f=RESET_PC, state=REQ.
  - instr_d=NOP_INSTR, pc_d=0, valid_d=0.
  - Hold buffer cleared; imem_req=0 while rst_n=0.
- Combinational outputs:
  - imem_req = (state==REQ) && !redirect.
  - imem_addr = pc_f.
- FSM states: REQ, WAIT, DROP, HOLD.
- REQ:
  - redirect: pc_f<=redirect_pc; stay in REQ.
  - else imem_gnt: go to WAIT.
  - else stay in REQ; address stays stable until granted.
- WAIT:
  - rvalid & redirect: discard data; pc_f<=redirect_pc; go to REQ.
  - rvalid & stall_d: capture {imem_rdata, pc_f} into the hold buffer; pc_f<=pc_f+4; go to HOLD.
  - rvalid, no stall: load IF/DE with {imem_rdata, pc_f, valid=1}; pc_f<=pc_f+4; go to REQ.
  - no rvalid & redirect: pc_f<=redirect_pc; go to DROP.
- DROP:
  - On rvalid, discard the response and go to REQ.
  - A further redirect while in DROP updates pc_f and stays in DROP.
- HOLD:
  - redirect: discard the buffer; pc_f<=redirect_pc; go to REQ.
  - else !stall_d: load IF/DE from the buffer; go to REQ.
- IF/DE register, priority in this order:
  - redirect: instr_d<=NOP_INSTR, valid_d<=0. Flush beats stall.
  - stall_d: hold all three outputs.
  - Load event (defined above): load.
  - Otherwise: bubble, instr_d<=NOP_INSTR, valid_d<=0; pc_d is held.
- Arithmetic: pc_f+4 is modulo 2^32; 32'hFFFF_FFFC wraps to 0.
- Throughput: with 1-cycle memory latency and immediate grant, one instruction every 2 cycles.
- Reset mid-transaction: the outstanding response is not tracked. The memory is reset by the same rst_n.

Test Plan:
- Reset release, gnt=1, rvalid 1 cycle after the grant, rdata=32'h00500093 → imem_addr=0x0, then instr_d=0x00500093, pc_d=0x0, valid_d=1; next imem_addr=0x4.
- Sequential fetch of 4 words → pc_d sequence 0x0, 0x4, 0x8, 0xC; valid_d=0 bubble between each.
- stall_d=1 when rvalid arrives with 0x00A00113 at pc 0x8 → IF/DE unchanged, state=HOLD; when stall_d drops, instr_d=0x00A00113, pc_d=0x8; next imem_addr=0xC.
- redirect=1, redirect_pc=0x103 during WAIT with no rvalid → DROP; the late rvalid is discarded and valid_d stays 0; next imem_addr=0x100.
- redirect and stall_d asserted together with valid_d=1 → valid_d=0, instr_d=0x00000013.
- pc_f=0xFFFFFFFC fetched without stall → next imem_addr=0x0.
